// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable down counter with one-shot and periodic modes.
// IDLE -> (load) -> RUN -> (expiry) -> DONE (one-shot) or RUN (periodic).
// Optional feature macro: FLEX_DOWN_COUNTER_EXPIRE_CNT_EN adds a saturating
// 8-bit count of expiry pulses on output expire_cnt.
// state_dbg exposes the FSM state encoding (IDLE=0, RUN=1, DONE=2).
// Input priority each cycle: rst > clear > load > count_enable.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    expire_flag,
    output logic                    done,
    output logic                    busy,
    output logic [1:0]              state_dbg
`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
    ,
    output logic [7:0]              expire_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    state_t                  r_state;
    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_CNT_BITS-1:0] r_reload;
    logic                    r_expire;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [NUM_CNT_BITS-1:0] w_count_nxt;
    logic [NUM_CNT_BITS-1:0] w_reload_nxt;
    logic                    w_expire_nxt;
    logic                    w_done_nxt;

    // State and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= CNT_ZERO;
            r_reload <= CNT_ZERO;
            r_expire <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_expire <= w_expire_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Next-state decode: clear > load > count_enable; enable only acts in RUN.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_expire_nxt = 1'b0;
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = CNT_ZERO;
        end else if (load) begin
            // A zero load parks the counter without signalling an expiry.
            if (load_val != CNT_ZERO) begin
                w_state_nxt  = ST_RUN;
                w_count_nxt  = load_val;
                w_reload_nxt = load_val;
            end else begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = CNT_ZERO;
            end
        end else if (count_enable && (r_state == ST_RUN)) begin
            if (r_count > CNT_ONE) begin
                w_count_nxt = r_count - CNT_ONE;
            end else if (r_count == CNT_ONE) begin
                w_expire_nxt = 1'b1;
                if (auto_reload) begin
                    w_count_nxt = r_reload;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_count_nxt = CNT_ZERO;
                end
            end
        end
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    assign count_out   = r_count;
    assign expire_flag = r_expire;
    assign done        = r_done;
    assign busy        = (r_state == ST_RUN);
    assign state_dbg   = r_state;

`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
    logic [7:0] r_xcnt;

    // Saturating expiry counter, updated in step with expire_flag; load keeps it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_xcnt <= 8'd0;
        end else if (w_expire_nxt && (r_xcnt != 8'd255)) begin
            r_xcnt <= r_xcnt + 8'd1;
        end
    end

    assign expire_cnt = r_xcnt;
`endif

endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: directed bench for flex_down_counter (NUM_CNT_BITS=4).
// Each step pushes the expected {count_out, expire_flag, done, busy} into a
// queue, applies one clock of stimulus, then pops and compares after the edge.
module tb_flex_down_counter;

    localparam int N = 4;
    localparam int W = N + 3;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         load;
    logic [N-1:0] load_val;
    logic         count_enable;
    logic         auto_reload;
    logic [N-1:0] count_out;
    logic         expire_flag;
    logic         done;
    logic         busy;
    logic [1:0]   state_dbg;
`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
    logic [7:0]   expire_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int           total;
    int           bad;

    flex_down_counter #(.NUM_CNT_BITS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .auto_reload  (auto_reload),
        .count_out    (count_out),
        .expire_flag  (expire_flag),
        .done         (done),
        .busy         (busy),
        .state_dbg    (state_dbg)
`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
        ,
        .expire_cnt   (expire_cnt)
`endif
    );

    // Clock block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: one cycle of stimulus, expectation pushed, then popped and checked.
    task automatic cyc(input string tag, input logic r, input logic c, input logic l,
                       input logic [N-1:0] lv, input logic en, input logic ar,
                       input logic [N-1:0] e_cnt, input logic e_exp,
                       input logic e_done, input logic e_busy);
        logic [W-1:0] obs;
        logic [W-1:0] expv;
        @(negedge clk);
        rst          = r;
        clear        = c;
        load         = l;
        load_val     = lv;
        count_enable = en;
        auto_reload  = ar;
        exp_q.push_back({e_cnt, e_exp, e_done, e_busy});
        @(posedge clk);
        #1;
        obs  = {count_out, expire_flag, done, busy};
        expv = exp_q.pop_front();
        total++;
        assert (obs === expv) else begin
            bad++;
            $display("FAIL %s: got cnt=%0d exp=%0b done=%0b busy=%0b, want cnt=%0d exp=%0b done=%0b busy=%0b",
                     tag, obs[W-1:3], obs[2], obs[1], obs[0],
                     expv[W-1:3], expv[2], expv[1], expv[0]);
            $error("check %s", tag);
        end
    endtask

    // Stimulus, scoreboard checks and final report.
    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        count_enable = 1'b0; auto_reload = 1'b0;

        // Reset state.
        cyc("reset",      1, 0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0);
        cyc("idle_en",    0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, 0);

        // One-shot: load 3 -> 3,2,1,0 with expiry on 0, then DONE holds.
        cyc("os_load",    0, 0, 1, 4'd3, 0, 0, 4'd3, 0, 0, 1);
        cyc("os_2",       0, 0, 0, 4'd0, 1, 0, 4'd2, 0, 0, 1);
        cyc("os_1",       0, 0, 0, 4'd0, 1, 0, 4'd1, 0, 0, 1);
        cyc("os_exp",     0, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1, 0);
        cyc("os_hold_a",  0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 1, 0);
        cyc("os_hold_b",  0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 1, 0);
        cyc("done_clear", 0, 1, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0);

        // Periodic: load 4, 12 enables -> 3,2,1,4(expire) repeating.
        cyc("per_load",   0, 0, 1, 4'd4, 0, 1, 4'd4, 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            if (i % 4 == 0) cyc("per_wrap", 0, 0, 0, 4'd0, 1, 1, 4'd4, 1, 0, 1);
            else            cyc("per_dec",  0, 0, 0, 4'd0, 1, 1, 4'(4 - (i % 4)), 0, 0, 1);
        end

        // Load 5 with enable toggling: holds on low cycles, expiry on 5th enable.
        cyc("tg_load",    0, 0, 1, 4'd5, 0, 0, 4'd5, 0, 0, 1);
        cyc("tg_e1",      0, 0, 0, 4'd0, 1, 0, 4'd4, 0, 0, 1);
        cyc("tg_h1",      0, 0, 0, 4'd0, 0, 0, 4'd4, 0, 0, 1);
        cyc("tg_e2",      0, 0, 0, 4'd0, 1, 0, 4'd3, 0, 0, 1);
        cyc("tg_h2",      0, 0, 0, 4'd0, 0, 0, 4'd3, 0, 0, 1);
        cyc("tg_e3",      0, 0, 0, 4'd0, 1, 0, 4'd2, 0, 0, 1);
        cyc("tg_h3",      0, 0, 0, 4'd0, 0, 0, 4'd2, 0, 0, 1);
        cyc("tg_e4",      0, 0, 0, 4'd0, 1, 0, 4'd1, 0, 0, 1);
        cyc("tg_h4",      0, 0, 0, 4'd0, 0, 0, 4'd1, 0, 0, 1);
        cyc("tg_e5",      0, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1, 0);
        cyc("tg_after",   0, 0, 0, 4'd0, 0, 0, 4'd0, 0, 1, 0);

        // Load beats a coincident expiry; clear aborts a running count.
        cyc("lx_load",    0, 0, 1, 4'd2, 0, 0, 4'd2, 0, 0, 1);
        cyc("lx_1",       0, 0, 0, 4'd0, 1, 0, 4'd1, 0, 0, 1);
        cyc("lx_reload",  0, 0, 1, 4'd9, 1, 0, 4'd9, 0, 0, 1);
        cyc("lx_dec",     0, 0, 0, 4'd0, 1, 0, 4'd8, 0, 0, 1);
        cyc("run_clear",  0, 1, 1, 4'd6, 1, 0, 4'd0, 0, 0, 0);

        // Load of zero from RUN parks in IDLE without a pulse.
        cyc("z_load",     0, 0, 1, 4'd3, 0, 0, 4'd3, 0, 0, 1);
        cyc("z_zero",     0, 0, 1, 4'd0, 1, 0, 4'd0, 0, 0, 0);
        cyc("z_idle",     0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0);

        // Reload value 1 in periodic mode: pulse every enabled cycle.
        cyc("one_load",   0, 0, 1, 4'd1, 0, 1, 4'd1, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            cyc("one_pulse", 0, 0, 0, 4'd0, 1, 1, 4'd1, 1, 0, 1);
        cyc("one_hold",   0, 0, 0, 4'd0, 0, 1, 4'd1, 0, 0, 1);
        cyc("one_ar_off", 0, 0, 0, 4'd0, 1, 0, 4'd0, 1, 1, 0);

        // rst mid-RUN with load asserted wins.
        cyc("r_load",     0, 0, 1, 4'd7, 0, 0, 4'd7, 0, 0, 1);
        cyc("r_dec",      0, 0, 0, 4'd0, 1, 0, 4'd6, 0, 0, 1);
        cyc("r_over",     1, 0, 1, 4'd5, 1, 1, 4'd0, 0, 0, 0);
        cyc("r_idle",     0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, 0);

`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
        // Saturating expiry count: 300 pulses saturate at 255; load keeps it; clear zeroes it.
        cyc("xc_load",    0, 0, 1, 4'd1, 0, 1, 4'd1, 0, 0, 1);
        for (int i = 0; i < 300; i++)
            cyc("xc_pulse", 0, 0, 0, 4'd0, 1, 1, 4'd1, 1, 0, 1);
        total++;
        assert (expire_cnt === 8'd255) else begin
            bad++;
            $display("FAIL xc_sat: got %0d want 255", expire_cnt);
            $error("check xc_sat");
        end
        cyc("xc_reload",  0, 0, 1, 4'd3, 0, 1, 4'd3, 0, 0, 1);
        total++;
        assert (expire_cnt === 8'd255) else begin
            bad++;
            $display("FAIL xc_keep: got %0d want 255", expire_cnt);
            $error("check xc_keep");
        end
        cyc("xc_clear",   0, 1, 0, 4'd0, 0, 1, 4'd0, 0, 0, 0);
        total++;
        assert (expire_cnt === 8'd0) else begin
            bad++;
            $display("FAIL xc_clear: got %0d want 0", expire_cnt);
            $error("check xc_clear");
        end
`endif

        // Final report.
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flex_down_counter.md
FLEX_DOWN_COUNTER -- requirements
Module: flex_down_counter

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, setting the width of load_val and count_out.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-005 SHALL have port load, input, 1, captures load_val and starts a count.
REQ-006 SHALL have port load_val, input, NUM_CNT_BITS, start/reload value.
REQ-007 SHALL have port count_enable, input, 1, decrement strobe.
REQ-008 SHALL have port auto_reload, input, 1; 1 = periodic mode, 0 = one-shot mode; sampled at each expiry.
REQ-009 SHALL have port count_out, output, NUM_CNT_BITS, registered current count.
REQ-010 SHALL have port expire_flag, output, 1, registered one-cycle pulse on each expiry.
REQ-011 SHALL have port done, output, 1, registered; high while in DONE.
REQ-012 SHALL have port busy, output, 1; high while in RUN; decoded from state only.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE, plus an internal NUM_CNT_BITS reload register.
REQ-014 SHALL apply input priority rst > clear > load > count_enable each cycle.
REQ-015 clear SHALL set state IDLE, count_out 0, expire_flag 0 and done 0 in the next cycle, from any state.
REQ-016 load with load_val != 0 SHALL set count_out = load_val, set reload register = load_val, enter RUN and drive done 0, from any state, including mid-count.
REQ-017 load with load_val == 0 SHALL enter IDLE with count_out 0 and SHALL NOT pulse expire_flag.
REQ-018 In RUN, with count_enable high and count_out > 1, count_out SHALL decrement by 1 in the next cycle.
REQ-019 In RUN, with count_enable low, count_out and state SHALL hold.
REQ-020 In RUN, with count_enable high and count_out == 1, the next cycle SHALL be an expiry: expire_flag = 1 for exactly that one cycle.
REQ-021 On expiry with auto_reload = 1, count_out SHALL take the reload register value and the state SHALL stay RUN.
REQ-022 On expiry with auto_reload = 0, count_out SHALL become 0, the state SHALL become DONE and done SHALL become 1.
REQ-023 The flag and count latency SHALL be one cycle; expire_flag SHALL coincide with the post-expiry count_out.
REQ-024 In IDLE and DONE, count_enable SHALL be ignored; count_out SHALL hold at 0.
REQ-025 DONE SHALL persist until load, clear or rst.
REQ-026 A load coincident with an expiry condition SHALL win: the new load_val is taken and expire_flag stays 0.
REQ-027 With reload value 1 in periodic mode, expire_flag SHALL pulse on every enabled cycle and count_out SHALL stay 1.
REQ-028 Arithmetic SHALL be unsigned, NUM_CNT_BITS wide, and SHALL never wrap below 0.

Reset
REQ-029 rst high at a rising clk edge SHALL set state IDLE, count_out 0, expire_flag 0, done 0, busy 0, the reload register 0 and, if compiled in, expire_cnt 0.
REQ-030 rst SHALL override all other inputs, including mid-count and on the cycle of a load.

Configuration
REQ-031 Macro FLEX_DOWN_COUNTER_EXPIRE_CNT_EN, when defined, SHALL add output expire_cnt [7:0].
REQ-032 With the macro defined, expire_cnt SHALL increment on each expire_flag pulse, saturate at 255, and be cleared only by rst or clear (not by load).
REQ-033 Without the macro, the expire_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Bench SHALL cover: rst held mid-RUN with load=1 -> next cycle count_out=0, busy=0, done=0, expire_flag=0.
REQ-035 Bench SHALL cover: NUM_CNT_BITS=4, load 3, auto_reload=0, enable high -> count_out 3,2,1,0; expire_flag=1 only with 0; done=1 afterwards; further enables leave count_out at 0.
REQ-036 Bench SHALL cover: load 4, auto_reload=1, enable high 12 cycles -> count_out 4,3,2,1,4,3,2,1,...; expire_flag pulses on every cycle where count_out returns to 4.
REQ-037 Bench SHALL cover: load 5, enable toggled 1/0 -> count_out holds on enable-low cycles, expiry after exactly 5 enabled cycles.
REQ-038 Bench SHALL cover: count_out=1 with enable high and load=1, load_val=9 -> count_out=9, expire_flag=0; clear while running -> IDLE, count_out=0.
REQ-039 Bench SHALL cover, with FLEX_DOWN_COUNTER_EXPIRE_CNT_EN defined: load 1, auto_reload=1, 300 enabled cycles -> expire_cnt=255; then clear -> expire_cnt=0.
